// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath selects, write enables and the DM handshake.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       npc_sel,
    output logic             reg_wr,
    output logic [1:0]       regDst,
    output logic             aluSrc,
    output logic [1:0]       memToReg,
    output logic [2:0]       alu_op,
    output logic             ext_op,
    output logic             dm_req,
    output logic             dm_we,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;

    localparam logic [3:0] ClsAddu = 4'd0;
    localparam logic [3:0] ClsSubu = 4'd1;
    localparam logic [3:0] ClsJr   = 4'd2;
    localparam logic [3:0] ClsOri  = 4'd3;
    localparam logic [3:0] ClsLui  = 4'd4;
    localparam logic [3:0] ClsLw   = 4'd5;
    localparam logic [3:0] ClsSw   = 4'd6;
    localparam logic [3:0] ClsBeq  = 4'd7;
    localparam logic [3:0] ClsJ    = 4'd8;
    localparam logic [3:0] ClsJal  = 4'd9;
    localparam logic [3:0] ClsIll  = 4'd10;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cls_q, cls_d, cls_dec;
    logic [CNT_W-1:0] retired_q;

    always_comb begin
        cls_dec = ClsIll;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   cls_dec = ClsAddu;
                    6'h23:   cls_dec = ClsSubu;
                    6'h08:   cls_dec = ClsJr;
                    default: cls_dec = ClsIll;
                endcase
            end
            6'h0d:   cls_dec = ClsOri;
            6'h0f:   cls_dec = ClsLui;
            6'h23:   cls_dec = ClsLw;
            6'h2b:   cls_dec = ClsSw;
            6'h04:   cls_dec = ClsBeq;
            6'h02:   cls_dec = ClsJ;
            6'h03:   cls_dec = ClsJal;
            default: cls_dec = ClsIll;
        endcase
    end

    // Class is captured only in DECODE so later IR changes cannot disturb the instruction.
    assign cls_d = (state_q == StDecode) ? cls_dec : cls_q;

    always_comb begin
        state_d  = state_q;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        npc_sel  = 2'd0;
        reg_wr   = 1'b0;
        regDst   = 2'd0;
        aluSrc   = 1'b0;
        memToReg = 2'd0;
        alu_op   = 3'd0;
        ext_op   = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                ir_wr   = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                state_d = StFetch;
                case (cls_dec)
                    ClsJ: begin
                        pc_wr   = 1'b1;
                        npc_sel = 2'd2;
                    end
                    ClsJal: begin
                        pc_wr    = 1'b1;
                        npc_sel  = 2'd2;
                        reg_wr   = 1'b1;
                        regDst   = 2'd2;
                        memToReg = 2'd3;
                    end
                    ClsJr: begin
                        pc_wr   = 1'b1;
                        npc_sel = 2'd3;
                    end
                    ClsIll: begin
                        illegal = 1'b1;
                        pc_wr   = 1'b1;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                state_d = StFetch;
                case (cls_q)
                    ClsAddu, ClsSubu: begin
                        reg_wr = 1'b1;
                        regDst = 2'd1;
                        alu_op = (cls_q == ClsSubu) ? 3'd1 : 3'd0;
                        pc_wr  = 1'b1;
                    end
                    ClsOri: begin
                        reg_wr = 1'b1;
                        aluSrc = 1'b1;
                        alu_op = 3'd2;
                        pc_wr  = 1'b1;
                    end
                    ClsLui: begin
                        reg_wr   = 1'b1;
                        memToReg = 2'd2;
                        pc_wr    = 1'b1;
                    end
                    ClsBeq: begin
                        alu_op  = 3'd1;
                        pc_wr   = 1'b1;
                        npc_sel = zero ? 2'd1 : 2'd0;
                    end
                    ClsLw, ClsSw: begin
                        aluSrc  = 1'b1;
                        ext_op  = 1'b1;
                        state_d = StMem;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                dm_req = 1'b1;
                dm_we  = (cls_q == ClsSw);
                aluSrc = 1'b1;
                ext_op = 1'b1;
                if (dm_ready) begin
                    if (cls_q == ClsSw) begin
                        pc_wr   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_wr   = 1'b1;
                memToReg = 2'd1;
                pc_wr    = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cls_q     <= ClsIll;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (pc_wr) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
